// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready bundle channel between pipeline stages
//
// Purpose: carries one stage bundle (control field + data field) with
// valid/ready flow control.
// Signals:
//   valid  bundle present this cycle (driven by the master)
//   ready  receiver accepts the bundle this cycle (driven by the slave)
//   ctrl   CTRL_W control field
//   data   DATA_W data field
// Modports: master drives valid/ctrl/data, slave drives ready.

interface pipe_stage_reg_if #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with flush, bubbles and stall counter
//
// Purpose: registers a stage bundle between two pipeline stages. The control
// field is forced to NOP_CTRL whenever the output holds no valid bundle, so a
// bubble or killed stage can never write architectural state. The data field
// is carried unchanged (held on bubbles/flushes).
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      kill this stage's contents (branch/jump redirect)
//   up         slave side: in_valid / in_ready / in_ctrl / in_data
//   dn         master side: out_valid / out_ready / out_ctrl / out_data
//   stall_cnt  saturating count of back-pressured cycles
// Build option: define PIPE_SKID_EN to register in_ready and add a single
// skid entry; otherwise in_ready is combinational and there is no skid.

module pipe_stage_reg #(
  parameter int                CTRL_W   = 24,
  parameter int                DATA_W   = 64,
  parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [DATA_W-1:0] out_data_q;
  logic              load;

  assign dn.valid = out_valid_q;
  assign dn.ctrl  = out_ctrl_q;
  assign dn.data  = out_data_q;

  // Output register is free when empty or being drained this cycle.
  assign load = !out_valid_q || dn.ready;

  // Counts cycles where a valid bundle is refused downstream; a flushed
  // cycle is not a stall because the bundle is being killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !dn.ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

`ifdef PIPE_SKID_EN
  logic              skid_valid_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              in_ready_q;
  logic              up_xfer;

  // in_ready_q always mirrors "skid empty" but is kept as its own flop so
  // the upstream ready path starts at a register.
  assign up.ready = in_ready_q;
  assign up_xfer  = up.valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_ctrl_q   <= NOP_CTRL;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= NOP_CTRL;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      out_ctrl_q   <= NOP_CTRL;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= NOP_CTRL;
      in_ready_q   <= 1'b1;
    end else if (load) begin
      if (skid_valid_q) begin
        // Older word waiting in the skid goes first to preserve order.
        out_valid_q  <= 1'b1;
        out_ctrl_q   <= skid_ctrl_q;
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else if (up_xfer) begin
        out_valid_q <= 1'b1;
        out_ctrl_q  <= up.ctrl;
        out_data_q  <= up.data;
      end else begin
        out_valid_q <= 1'b0;
        out_ctrl_q  <= NOP_CTRL;
      end
    end else if (up_xfer) begin
      // Output is held: park the accepted word and close the input.
      skid_valid_q <= 1'b1;
      skid_ctrl_q  <= up.ctrl;
      skid_data_q  <= up.data;
      in_ready_q   <= 1'b0;
    end
  end
`else
  // Flush empties the stage, so a word offered during flush is accepted
  // and dropped rather than left stuck upstream.
  assign up.ready = load || flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= NOP_CTRL;
      out_data_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= NOP_CTRL;
    end else if (load) begin
      if (up.valid) begin
        out_valid_q <= 1'b1;
        out_ctrl_q  <= up.ctrl;
        out_data_q  <= up.data;
      end else begin
        out_valid_q <= 1'b0;
        out_ctrl_q  <= NOP_CTRL;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard testbench for pipe_stage_reg

module tb_pipe_stage_reg;
  localparam int CTRL_W = 24;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;
  localparam logic [CTRL_W-1:0] NOP = '0;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_CTRL(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up(up_if), .dn(dn_if), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every downstream transfer against the scoreboard.
  always @(negedge clk) begin
    word_t e;
    if (rst_n) begin
      if (dn_if.valid && dn_if.ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out: got data 0x%0h, expected no output", dn_if.data);
        end else begin
          e = exp_q.pop_front();
          chk("out_ctrl", 64'(dn_if.ctrl), 64'(e.c));
          chk("out_data", dn_if.data, e.d);
        end
      end
      if (!dn_if.valid) chk("nop_invariant", 64'(dn_if.ctrl), 64'(NOP));
    end
  end

  // One cycle of stimulus; records accepted words as expected outputs.
  task automatic step(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy, input logic fl, output logic acc);
    @(posedge clk);
    #1;
    up_if.valid = iv;
    up_if.ctrl  = c;
    up_if.data  = d;
    dn_if.ready = ordy;
    flush       = fl;
    @(negedge clk);
    acc = iv && up_if.ready && !fl;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(word_t'({c, d}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        got;
    int          n_acc;
    logic [63:0] w;

    up_if.valid = 1'b0;
    up_if.ctrl  = '0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(dn_if.valid), 64'd0);
    chk("rst_out_ctrl", 64'(dn_if.ctrl), 64'(NOP));
    chk("rst_out_data", dn_if.data, 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(up_if.ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, CTRL_W'(i * 'h10101), 64'(i), 1'b1, 1'b0, acc);
      chk("stream_in_ready", 64'(up_if.ready), 64'd1);
      if (i > 1) chk("stream_no_gap", 64'(dn_if.valid), 64'd1);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Stall for 5 cycles with a word held at the output
    step(1'b1, 24'hA5A5A5, 64'hA0, 1'b1, 1'b0, acc);
    w = 64'hB0;
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, CTRL_W'(w), w, 1'b0, 1'b0, acc);
      chk("stall_hold_data", dn_if.data, 64'hA0);
      chk("stall_hold_ctrl", 64'(dn_if.ctrl), 64'hA5A5A5);
      chk("stall_in_ready", 64'(up_if.ready), 64'(SKID && (k == 0)));
      if (acc) begin
        n_acc++;
        w = w + 64'h10;
      end
    end
    chk("stall_extra_words", 64'(n_acc), 64'(SKID ? 1 : 0));
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(!got, CTRL_W'(w), w, 1'b1, 1'b0, acc);
      if (k == 0) chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
      if (acc) got = 1'b1;
    end

    // Flush against a stall and a simultaneous upstream word
    step(1'b1, 24'h0E0E0E, 64'hE0, 1'b1, 1'b0, acc);
    step(1'b1, 24'h0F0F0F, 64'hF0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("flush_out_valid", 64'(dn_if.valid), 64'd0);
    chk("flush_out_ctrl", 64'(dn_if.ctrl), 64'(NOP));
    chk("flush_out_data_held", dn_if.data, 64'hE0);
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd5);
    chk("flush_in_ready", 64'(up_if.ready), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Bubble inside a stream of all-ones control
    for (int i = 0; i < 5; i++) begin
      step(i != 2, 24'hFFFFFF, 64'h101 + 64'(i), 1'b1, 1'b0, acc);
      if (i == 2) begin
        chk("bubble_prev_valid", 64'(dn_if.valid), 64'd1);
        chk("bubble_prev_ctrl", 64'(dn_if.ctrl), 64'hFFFFFF);
      end
      if (i == 3) begin
        chk("bubble_valid", 64'(dn_if.valid), 64'd0);
        chk("bubble_ctrl", 64'(dn_if.ctrl), 64'h000000);
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-stream
    step(1'b1, 24'h020202, 64'h201, 1'b1, 1'b0, acc);
    step(1'b1, 24'h020202, 64'h202, 1'b1, 1'b0, acc);
    @(posedge clk);
    #3;
    chk("pre_rst_out_valid", 64'(dn_if.valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(dn_if.valid), 64'd0);
    chk("async_rst_out_ctrl", 64'(dn_if.ctrl), 64'(NOP));
    chk("async_rst_out_data", dn_if.data, 64'd0);
    chk("async_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("async_rst_in_ready", 64'(up_if.ready), 64'd1);
    up_if.valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the 4-bit stall counter
    step(1'b1, 24'h030303, 64'h300, 1'b1, 1'b0, acc);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, acc);
      chk("sat_cnt", 64'(stall_cnt), 64'((k < 15) ? k : 15));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("sat_hold", 64'(stall_cnt), 64'd15);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the pipelined core (ID/RR, RR/EX, EX/MEM, MEM/WB boundaries).
- Splits the stage bundle into two fields:
  - a control field, forced to a NOP pattern on bubbles and flushes;
  - a data field, carried unchanged.
- Adds valid/ready flow control, flush, async reset and a saturating stall-cycle counter, so hazard logic can stall or kill a stage without ad-hoc muxing.

Parameters:
CTRL_W, 24, width of control field (mux selects, write enables, alu_op, flag enables)
DATA_W, 64, width of data field (PC, PC+1, register indices, immediates)
NOP_CTRL, {CTRL_W{1'b0}}, control pattern driven on bubble/flush/reset; must deassert every write enable
CNT_W, 8, width of stall counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill contents of this stage (branch/jump redirect)
in_valid  in  1  upstream bundle valid
in_ready  out  1  stage can accept the upstream bundle this cycle
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream data field
out_valid  out  1  registered bundle valid
out_ready  in  1  downstream accepts the bundle this cycle
out_ctrl  out  CTRL_W  registered control field
out_data  out  DATA_W  registered data field
stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Reset (rst_n=0, async, takes effect immediately, including mid-transfer):
  - out_valid=0, out_ctrl=NOP_CTRL, out_data=0, stall_cnt=0;
  - in_ready=1 (held 1 when PIPE_SKID_EN);
  - skid entry emptied.
- Transfers:
  - upstream transfer = in_valid & in_ready;
  - downstream transfer = out_valid & out_ready;
  - latency 1 cycle from upstream transfer to out_valid.
- Load condition: load = !out_valid | out_ready.
- Base mode (PIPE_SKID_EN undefined):
  - in_ready = load | flush (combinational).
  - On clk with flush=1: out_valid<=0, out_ctrl<=NOP_CTRL, out_data held; any word transferred that cycle is dropped.
  - Else if load & in_valid: out_valid<=1, out_ctrl<=in_ctrl, out_data<=in_data.
  - Else if load & !in_valid: bubble; out_valid<=0, out_ctrl<=NOP_CTRL, out_data held.
  - Else (stalled): all outputs hold.
- Priority: reset > flush > load > hold. Flush has priority over a simultaneous stall and over a simultaneous upstream transfer.
- Invariant: out_valid=0 implies out_ctrl==NOP_CTRL, so a bubble can never write the register file, memory or flags.
- stall_cnt:
  - increments on any clk where out_valid & !out_ready & !flush;
  - saturates at all-ones; no wrap;
  - not cleared by flush; cleared only by reset.
- Ordering: the stage never reorders or duplicates bundles. Every upstream transfer appears exactly once at the output unless it is flushed.

Optional Feature:
- Macro PIPE_SKID_EN.
- Defined:
  - in_ready is a registered signal, breaking the ready path through the stage.
  - A single skid entry (ctrl+data+valid) is added.
  - in_ready = skid empty.
  - If an upstream transfer occurs while the output is held (out_valid & !out_ready), the word goes to the skid entry and in_ready<=0.
  - When load is true, the output takes the skid entry if it is occupied (skid then empties, in_ready<=1); otherwise it takes the input as in base mode.
  - Flush empties both output and skid, out_ctrl<=NOP_CTRL, in_ready<=1.
  - Throughput is 1 word/cycle while out_ready=1; at most 2 words are buffered.
- Undefined: no skid storage; in_ready is combinational as above.

Test Plan:
- Reset mid-stream: stream bundles, drop rst_n asynchronously between edges -> out_valid=0, out_ctrl=NOP_CTRL, out_data=0, stall_cnt=0 immediately without waiting for clk.
- Streaming: in_valid=1, out_ready=1, data 0x0001..0x0010 on consecutive cycles -> identical sequence on out_data one cycle later, no gaps, in_ready constantly 1.
- Stall: hold out_ready=0 for 5 cycles with out_valid=1 -> out_ctrl/out_data unchanged, stall_cnt=5. Base mode: in_ready=0. Skid mode: exactly one extra word accepted, then in_ready=0. After out_ready=1 both words emerge in order.
- Flush vs stall: flush=1 with out_ready=0 and in_valid=1 -> next cycle out_valid=0, out_ctrl=NOP_CTRL, skid empty, the accepted word never appears, stall_cnt unchanged that cycle.
- Bubble: in_valid=0 for one cycle in a stream of control 0xFFFFFF -> one cycle with out_valid=0 and out_ctrl=0x000000, neighbouring bundles intact.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds at 15.
